// File: rtl/uart_time_pkg.sv
// Shared constants, FSM encodings and range helper for the UART time/date setter.
package uart_time_pkg;

  localparam logic [7:0] CMD_T   = 8'h54;
  localparam logic [7:0] CMD_D   = 8'h44;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] DIGIT_0 = 8'h30;
  localparam logic [7:0] DIGIT_9 = 8'h39;

  localparam logic [3:0] TIME_DIGITS = 4'd6;
  localparam logic [3:0] DATE_DIGITS = 4'd8;

  // Reset date 01-01-2000 as BCD ddmmccyy, most significant digit first.
  localparam logic [31:0] RST_DATE = 32'h0101_2000;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop
  } rx_state_e;

  typedef enum logic [1:0] {
    PIdle,
    PTime,
    PDate
  } parse_state_e;

  function automatic logic in_range(input logic [3:0] tens, input logic [3:0] ones,
                                    input int lo, input int hi);
    int v;
    v = 10 * int'(tens) + int'(ones);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 2-flop synchroniser plus UART byte receiver (8N1; 8E1 when UART_PARITY_EN is defined).
module uart_rx_byte
  import uart_time_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta_q, rx_sync_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            par_ok;

`ifdef UART_PARITY_EN
  logic par_ok_q, par_ok_d;
  assign par_ok = par_ok_q;
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
    par_ok_d = par_ok_q;
`endif
    case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (!rx_sync_q) state_d = RxStart;
      end
      RxStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = RxParity;
`else
            state_d = RxStop;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RxParity: begin
        if (cnt_q == BitLast) begin
          cnt_d    = '0;
          par_ok_d = ~(^{rx_sync_q, shift_q});
          state_d  = RxStop;
        end
      end
`endif
      RxStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = RxIdle;
          if (rx_sync_q && par_ok) valid_d = 1'b1;
          else                     ferr_d  = 1'b1;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_PARITY_EN
      par_ok_q  <= 1'b1;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_PARITY_EN
      par_ok_q  <= par_ok_d;
`endif
    end
  end

  assign data       = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_time_set_rx.sv
// Parses "Thhmmss<CR>" / "Dddmmccyy<CR>" from UART and commits BCD time/date digits.
// Define UART_PARITY_EN for 8E1 framing (handled in uart_rx_byte).
module uart_time_set_rx
  import uart_time_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       rx,
  output logic [3:0] hr_10s,
  output logic [3:0] hr_1s,
  output logic [3:0] min_10s,
  output logic [3:0] min_1s,
  output logic [3:0] sec_10s,
  output logic [3:0] sec_1s,
  output logic [3:0] d_10s,
  output logic [3:0] d_1s,
  output logic [3:0] m_10s,
  output logic [3:0] m_1s,
  output logic [3:0] c_10s,
  output logic [3:0] c_1s,
  output logic [3:0] y_10s,
  output logic [3:0] y_1s,
  output logic       set_time,
  output logic       set_date,
  output logic       cmd_err,
  output logic       frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .rx        (rx),
    .data      (rx_data),
    .byte_valid(rx_valid),
    .frame_err (rx_ferr)
  );

  parse_state_e pstate_q, pstate_d;
  logic [3:0]   idx_q, idx_d;
  logic [3:0]   shadow_q [8];
  logic [3:0]   shadow_d [8];
  logic [3:0]   time_q [6];
  logic [3:0]   time_d [6];
  logic [3:0]   date_q [8];
  logic [3:0]   date_d [8];
  logic         set_time_q, set_time_d;
  logic         set_date_q, set_date_d;
  logic         cmd_err_q, cmd_err_d;

  logic       is_digit, is_cmd, time_ok, date_ok, field_ok;
  logic [3:0] digit_max;

  assign is_digit  = (rx_data >= DIGIT_0) && (rx_data <= DIGIT_9);
  assign is_cmd    = (rx_data == CMD_T) || (rx_data == CMD_D);
  assign digit_max = (pstate_q == PTime) ? TIME_DIGITS : DATE_DIGITS;

  assign time_ok = in_range(shadow_q[0], shadow_q[1], 0, 23) &&
                   in_range(shadow_q[2], shadow_q[3], 0, 59) &&
                   in_range(shadow_q[4], shadow_q[5], 0, 59);
  // Day is not checked against month; the calendar owns that.
  assign date_ok = in_range(shadow_q[0], shadow_q[1], 1, 31) &&
                   in_range(shadow_q[2], shadow_q[3], 1, 12);
  assign field_ok = (pstate_q == PTime) ? time_ok : date_ok;

  always_comb begin
    pstate_d   = pstate_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    time_d     = time_q;
    date_d     = date_q;
    set_time_d = 1'b0;
    set_date_d = 1'b0;
    cmd_err_d  = 1'b0;
    if (rx_ferr) begin
      pstate_d = PIdle;
    end else if (rx_valid) begin
      case (pstate_q)
        PIdle: begin
          if (is_cmd) begin
            pstate_d = (rx_data == CMD_T) ? PTime : PDate;
            idx_d    = '0;
            for (int i = 0; i < 8; i++) shadow_d[i] = '0;
          end
        end
        PTime, PDate: begin
          if (is_cmd) begin
            cmd_err_d = 1'b1;
            pstate_d  = (rx_data == CMD_T) ? PTime : PDate;
            idx_d     = '0;
            for (int i = 0; i < 8; i++) shadow_d[i] = '0;
          end else if (is_digit) begin
            if (idx_q == digit_max) begin
              cmd_err_d = 1'b1;
              pstate_d  = PIdle;
            end else begin
              // ASCII '0'-'9' low nibble equals byte - 0x30.
              shadow_d[idx_q[2:0]] = rx_data[3:0];
              idx_d                = idx_q + 4'd1;
            end
          end else if (rx_data == CR) begin
            pstate_d = PIdle;
            if ((idx_q == digit_max) && field_ok) begin
              if (pstate_q == PTime) begin
                for (int i = 0; i < 6; i++) time_d[i] = shadow_q[i];
                set_time_d = 1'b1;
              end else begin
                date_d     = shadow_q;
                set_date_d = 1'b1;
              end
            end else begin
              cmd_err_d = 1'b1;
            end
          end else begin
            cmd_err_d = 1'b1;
            pstate_d  = PIdle;
          end
        end
        default: pstate_d = PIdle;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      pstate_q   <= PIdle;
      idx_q      <= '0;
      for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
      for (int i = 0; i < 6; i++) time_q[i] <= '0;
      for (int i = 0; i < 8; i++) date_q[i] <= RST_DATE[31-4*i -: 4];
      set_time_q <= 1'b0;
      set_date_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      pstate_q   <= pstate_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      time_q     <= time_d;
      date_q     <= date_d;
      set_time_q <= set_time_d;
      set_date_q <= set_date_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign hr_10s  = time_q[0];
  assign hr_1s   = time_q[1];
  assign min_10s = time_q[2];
  assign min_1s  = time_q[3];
  assign sec_10s = time_q[4];
  assign sec_1s  = time_q[5];
  assign d_10s   = date_q[0];
  assign d_1s    = date_q[1];
  assign m_10s   = date_q[2];
  assign m_1s    = date_q[3];
  assign c_10s   = date_q[4];
  assign c_1s    = date_q[5];
  assign y_10s   = date_q[6];
  assign y_1s    = date_q[7];

  assign set_time  = set_time_q;
  assign set_date  = set_date_q;
  assign cmd_err   = cmd_err_q;
  assign frame_err = rx_ferr;

endmodule
